req_ack_timer: RTL and testbench

REQ_ACK_TIMER -- requirements
Module: req_ack_timer

---
 rtl/req_ack_timer_pkg.sv | 13 +
 rtl/req_ack_sat_cnt.sv | 25 ++
 rtl/req_ack_timer.sv | 92 +++++++++
 tb/tb_req_ack_timer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/req_ack_timer_pkg.sv
// Shared definitions for the request/acknowledge timeout checker.
package req_ack_timer_pkg;

  localparam int TIMEOUT_CYC_DEF = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ACK   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/req_ack_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at MAX instead of wrapping.
module req_ack_sat_cnt #(
  parameter int WIDTH = 5,
  parameter int MAX   = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != MAX_Q)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/req_ack_timer.sv
// Watches one request/grant handshake and reports ack, protocol error or timeout.
module req_ack_timer
  import req_ack_timer_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_in,
  input  logic             grant,
  input  logic             abort_sig,
  output logic             req,
  output logic             ack,
  output logic             error,
  output logic             timeout,
  output logic             busy,
  output logic [CNT_W-1:0] wait_cnt
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

  state_t state, state_nxt;
  logic   ack_nxt, error_nxt, timeout_nxt;

  // Counter is held at zero outside WAIT, so every WAIT starts from 0.
  req_ack_sat_cnt #(
    .WIDTH (CNT_W),
    .MAX   (TIMEOUT_CYC)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state != ST_WAIT),
    .inc   (state == ST_WAIT),
    .q     (wait_cnt)
  );

  always_comb begin
    state_nxt   = state;
    ack_nxt     = 1'b0;
    error_nxt   = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_in && !abort_sig) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (abort_sig) begin
          state_nxt = ST_IDLE;
        end else if (grant) begin
          state_nxt = ST_ACK;
          ack_nxt   = 1'b1;
        end else if (!req_in) begin
          state_nxt = ST_IDLE;
          error_nxt = 1'b1;
        end else if (wait_cnt == LAST_CNT) begin
          state_nxt   = ST_DRAIN;
          timeout_nxt = 1'b1;
        end
      end
      ST_ACK: begin
        state_nxt = ST_IDLE;
      end
      ST_DRAIN: begin
        if (abort_sig || !req_in) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      req     <= 1'b0;
      ack     <= 1'b0;
      error   <= 1'b0;
      timeout <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      req     <= (state_nxt == ST_WAIT);
      ack     <= ack_nxt;
      error   <= error_nxt;
      timeout <= timeout_nxt;
      busy    <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_req_ack_timer.sv
// Self-checking bench: directed vector table, hand sequences and a randomized run against a model.
module tb_req_ack_timer;

  localparam int TIMEOUT = 20;
  localparam int CNT_W   = $clog2(TIMEOUT + 1);

  logic             clk;
  logic             rst_n;
  logic             req_in;
  logic             grant;
  logic             abort_sig;
  logic             req;
  logic             ack;
  logic             error;
  logic             timeout;
  logic             busy;
  logic [CNT_W-1:0] wait_cnt;

  int total = 0;
  int bad   = 0;

  req_ack_timer #(
    .TIMEOUT_CYC (TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_in    (req_in),
    .grant     (grant),
    .abort_sig (abort_sig),
    .req       (req),
    .ack       (ack),
    .error     (error),
    .timeout   (timeout),
    .busy      (busy),
    .wait_cnt  (wait_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Transaction-level model: an open request ages each cycle until it is resolved.
  bit m_open;
  bit m_drain;
  bit m_ack_p, m_err_p, m_to_p;
  int m_age;

  task automatic model_reset();
    m_open = 0; m_drain = 0; m_age = 0;
    m_ack_p = 0; m_err_p = 0; m_to_p = 0;
  endtask

  task automatic model_step(input bit r, input bit g, input bit a);
    bit was_ack;
    was_ack = m_ack_p;
    m_ack_p = 0; m_err_p = 0; m_to_p = 0;
    if (m_open) begin
      if (a)                        m_open = 0;
      else if (g)                   begin m_open = 0; m_ack_p = 1; end
      else if (!r)                  begin m_open = 0; m_err_p = 1; end
      else if (m_age == TIMEOUT - 1) begin m_open = 0; m_drain = 1; m_to_p = 1; end
      else                          m_age = m_age + 1;
    end else if (m_drain) begin
      if (a || !r) m_drain = 0;
    end else if (!was_ack && r && !a) begin
      m_open = 1;
      m_age  = 0;
    end
  endtask

  task automatic check_output(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input bit r, input bit g, input bit a);
    req_in = r; grant = g; abort_sig = a;
    @(posedge clk);
    model_step(r, g, a);
    #1;
  endtask

  task automatic check_model(input string tag);
    check_output({tag, " req"},     req,     m_open);
    check_output({tag, " ack"},     ack,     m_ack_p);
    check_output({tag, " error"},   error,   m_err_p);
    check_output({tag, " timeout"}, timeout, m_to_p);
    check_output({tag, " busy"},    busy,    m_open || m_drain || m_ack_p);
    if (m_open) check_output({tag, " wait_cnt"}, wait_cnt, m_age);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, " req"},      req,      0);
    check_output({tag, " ack"},      ack,      0);
    check_output({tag, " error"},    error,    0);
    check_output({tag, " timeout"},  timeout,  0);
    check_output({tag, " busy"},     busy,     0);
    check_output({tag, " wait_cnt"}, wait_cnt, 0);
  endtask

  typedef struct {
    bit r, g, a;
    bit e_req, e_ack, e_err, e_to, e_busy;
    int e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(bit r, bit g, bit a, bit q, bit k, bit e, bit t, bit b, int c);
    vec_t v;
    v.r = r; v.g = g; v.a = a;
    v.e_req = q; v.e_ack = k; v.e_err = e; v.e_to = t; v.e_busy = b; v.e_cnt = c;
    vecs.push_back(v);
  endfunction

  initial begin
    bit r_cur;
    int to_seen;
    req_in = 0; grant = 0; abort_sig = 0;
    rst_n = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    #2 check_all_zero("reset_async");
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset_held");
    rst_n = 1'b1;

    // req, grant, abort -> req ack err to busy cnt
    add_vec(1,0,0, 1,0,0,0,1, 0);
    add_vec(1,0,0, 1,0,0,0,1, 1);
    add_vec(1,0,0, 1,0,0,0,1, 2);
    add_vec(1,1,0, 0,1,0,0,1, 0);
    add_vec(0,0,0, 0,0,0,0,0, 0);
    add_vec(1,0,0, 1,0,0,0,1, 0);
    add_vec(1,0,0, 1,0,0,0,1, 1);
    add_vec(1,1,1, 0,0,0,0,0, 0);
    add_vec(0,0,0, 0,0,0,0,0, 0);
    add_vec(1,0,0, 1,0,0,0,1, 0);
    add_vec(1,0,0, 1,0,0,0,1, 1);
    add_vec(1,0,0, 1,0,0,0,1, 2);
    add_vec(1,0,0, 1,0,0,0,1, 3);
    add_vec(0,0,0, 0,0,1,0,0, 0);
    add_vec(0,0,0, 0,0,0,0,0, 0);
    add_vec(0,1,0, 0,0,0,0,0, 0);
    add_vec(1,0,1, 0,0,0,0,0, 0);
    add_vec(0,0,0, 0,0,0,0,0, 0);

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      apply_stimulus(vecs[i].r, vecs[i].g, vecs[i].a);
      check_output({tag, " req"},     req,     vecs[i].e_req);
      check_output({tag, " ack"},     ack,     vecs[i].e_ack);
      check_output({tag, " error"},   error,   vecs[i].e_err);
      check_output({tag, " timeout"}, timeout, vecs[i].e_to);
      check_output({tag, " busy"},    busy,    vecs[i].e_busy);
      if (vecs[i].e_req) check_output({tag, " wait_cnt"}, wait_cnt, vecs[i].e_cnt);
    end

    // Timeout with request held, then drain with stray grants.
    to_seen = 0;
    for (int i = 0; i <= TIMEOUT; i++) begin
      apply_stimulus(1, 0, 0);
      if (timeout) to_seen++;
      if (i < TIMEOUT) begin
        check_output($sformatf("to_run%0d wait_cnt", i), wait_cnt, i);
        check_output($sformatf("to_run%0d timeout", i), timeout, 0);
      end else begin
        check_output("to_fire timeout", timeout, 1);
        check_output("to_fire busy", busy, 1);
        check_output("to_fire req", req, 0);
      end
    end
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1, i[0], 0);
      if (timeout) to_seen++;
      check_output($sformatf("drain%0d busy", i), busy, 1);
      check_output($sformatf("drain%0d ack", i), ack, 0);
      check_output($sformatf("drain%0d req", i), req, 0);
    end
    check_output("timeout_once", to_seen, 1);
    apply_stimulus(0, 0, 0);
    check_output("drain_exit busy", busy, 0);

    // Grant on the final count wins over timeout.
    for (int i = 0; i < TIMEOUT; i++) apply_stimulus(1, 0, 0);
    check_output("final_cnt wait_cnt", wait_cnt, TIMEOUT - 1);
    apply_stimulus(1, 1, 0);
    check_output("final_grant ack", ack, 1);
    check_output("final_grant timeout", timeout, 0);
    apply_stimulus(0, 0, 0);
    check_output("final_grant busy", busy, 0);

    // Reset in the middle of WAIT, then a fresh request.
    for (int i = 0; i < 6; i++) apply_stimulus(1, 0, 0);
    check_output("pre_reset wait_cnt", wait_cnt, 5);
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid_reset");
    model_reset();
    #1 rst_n = 1'b1;
    apply_stimulus(1, 0, 0);
    check_output("restart req", req, 1);
    check_output("restart wait_cnt", wait_cnt, 0);
    apply_stimulus(1, 0, 0);
    check_output("restart wait_cnt+1", wait_cnt, 1);
    apply_stimulus(0, 0, 0);
    check_model("restart_drop");

    // Randomized run; segment 1 disables grant so timeouts occur.
    r_cur = 0;
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 150; i++) begin
        bit g, a;
        if ($urandom_range(0, 9) == 0) r_cur = ~r_cur;
        case (s)
          0: g = ($urandom_range(0, 3) == 0);
          1: g = 1'b0;
          2: g = ($urandom_range(0, 15) == 0);
          default: g = ($urandom_range(0, 1) == 0);
        endcase
        a = ($urandom_range(0, 19) == 0);
        apply_stimulus(r_cur, g, a);
        check_model($sformatf("rand%0d_%0d", s, i));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
